sr_latch: RTL and testbench

Clocked, synchronous SR storage element bank: each of WIDTH independent bits is set, reset or held on every rising clock edge from its S/R input pair, with complementary Q/Qn outputs. The S=R=1 input combination is handled deterministically by a selectable policy and reported through per-bit, sticky and counted error flags. Used wherever control logic needs set/clear flag storage with visibility of illegal command collisions.

---
 rtl/sr_latch.sv | 111 +++++++++++
 tb/tb_sr_latch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sr_latch.sv
// sr_latch: bank of WIDTH clocked SR bits with a selectable S=R=1 policy and collision flags.
// Latency: 1 clk from S/R/clr_err sampling to Q/Qn/err/err_sticky/err_cnt; all outputs registered.
// Backpressure: none; every edge is accepted and the inputs are not stalled.
module sr_latch #(
  parameter int WIDTH       = 1,
  parameter int FORBID_MODE = 0,  // 0: both outputs low, 1: set-dominant, 2: reset-dominant
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Q and Qn are stored separately: mode 0 needs the Q=0/Qn=0 invalid state,
  // which cannot be represented by a single bit.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qn;
  logic [WIDTH-1:0] r_err;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_qn_nxt;
  logic [WIDTH-1:0] w_collide;
  logic             w_any;

  assign w_collide = S & R;
  assign w_any     = |w_collide;

  // Per-bit next state from the sampled {S,R} pair; bits never interact.
  always_comb begin
    w_q_nxt  = r_q;
    w_qn_nxt = r_qn;
    for (int i = 0; i < WIDTH; i++) begin
      case ({S[i], R[i]})
        2'b10: begin
          w_q_nxt[i]  = 1'b1;
          w_qn_nxt[i] = 1'b0;
        end
        2'b01: begin
          w_q_nxt[i]  = 1'b0;
          w_qn_nxt[i] = 1'b1;
        end
        2'b11: begin
          if (FORBID_MODE == 1) begin
            w_q_nxt[i]  = 1'b1;
            w_qn_nxt[i] = 1'b0;
          end else if (FORBID_MODE == 2) begin
            w_q_nxt[i]  = 1'b0;
            w_qn_nxt[i] = 1'b1;
          end else begin
            // Any unrecognised mode falls back to the NOR-latch behaviour.
            w_q_nxt[i]  = 1'b0;
            w_qn_nxt[i] = 1'b0;
          end
        end
        default: begin
          // Hold; an invalid (0/0) bit settles into the reset state.
          if (!r_q[i] && !r_qn[i]) begin
            w_qn_nxt[i] = 1'b1;
          end
        end
      endcase
    end
  end

  // Storage bits and per-bit collision flag; reset dominates everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_qn  <= '1;
      r_err <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_qn  <= w_qn_nxt;
      r_err <= w_collide;
    end
  end

  // Sticky flag and saturating event counter; clr_err beats a same-edge collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (clr_err) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_any) begin
      r_sticky <= 1'b1;
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Q          = r_q;
  assign Qn         = r_qn;
  assign err        = r_err;
  assign err_sticky = r_sticky;
  assign err_cnt    = r_cnt;

endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: directed vectors over several parameterisations of sr_latch.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_sr_latch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // m0: WIDTH=1, mode 0
  logic       m0_s, m0_r, m0_clr, m0_q, m0_qn, m0_err, m0_stk;
  logic [7:0] m0_cnt;
  // m1: WIDTH=1, mode 1
  logic       m1_s, m1_r, m1_clr, m1_q, m1_qn, m1_err, m1_stk;
  logic [7:0] m1_cnt;
  // m2: WIDTH=1, mode 2
  logic       m2_s, m2_r, m2_clr, m2_q, m2_qn, m2_err, m2_stk;
  logic [7:0] m2_cnt;
  // w4: WIDTH=4, mode 0
  logic [3:0] w4_s, w4_r, w4_q, w4_qn, w4_err;
  logic       w4_clr, w4_stk;
  logic [7:0] w4_cnt;
  // c2: WIDTH=1, mode 0, CNT_W=2
  logic       c2_s, c2_r, c2_clr, c2_q, c2_qn, c2_err, c2_stk;
  logic [1:0] c2_cnt;

  sr_latch #(.WIDTH(1), .FORBID_MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .rst_n(rst_n), .S(m0_s), .R(m0_r), .clr_err(m0_clr),
    .Q(m0_q), .Qn(m0_qn), .err(m0_err), .err_sticky(m0_stk), .err_cnt(m0_cnt));
  sr_latch #(.WIDTH(1), .FORBID_MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .rst_n(rst_n), .S(m1_s), .R(m1_r), .clr_err(m1_clr),
    .Q(m1_q), .Qn(m1_qn), .err(m1_err), .err_sticky(m1_stk), .err_cnt(m1_cnt));
  sr_latch #(.WIDTH(1), .FORBID_MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .rst_n(rst_n), .S(m2_s), .R(m2_r), .clr_err(m2_clr),
    .Q(m2_q), .Qn(m2_qn), .err(m2_err), .err_sticky(m2_stk), .err_cnt(m2_cnt));
  sr_latch #(.WIDTH(4), .FORBID_MODE(0), .CNT_W(8)) u_w4 (
    .clk(clk), .rst_n(rst_n), .S(w4_s), .R(w4_r), .clr_err(w4_clr),
    .Q(w4_q), .Qn(w4_qn), .err(w4_err), .err_sticky(w4_stk), .err_cnt(w4_cnt));
  sr_latch #(.WIDTH(1), .FORBID_MODE(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .S(c2_s), .R(c2_r), .clr_err(c2_clr),
    .Q(c2_q), .Qn(c2_qn), .err(c2_err), .err_sticky(c2_stk), .err_cnt(c2_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // m0 single-bit vector: drive, clock, check Q/Qn/err.
  task automatic m0_vec(input string tag, input logic s, input logic r,
                        input logic eq, input logic eqn, input logic eerr);
    m0_s = s;
    m0_r = r;
    step();
    chk({tag, ".Q"},   32'(m0_q),   32'(eq));
    chk({tag, ".Qn"},  32'(m0_qn),  32'(eqn));
    chk({tag, ".err"}, 32'(m0_err), 32'(eerr));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {m0_s, m0_r, m0_clr} = '0;
    {m1_s, m1_r, m1_clr} = '0;
    {m2_s, m2_r, m2_clr} = '0;
    w4_s = 4'b0; w4_r = 4'b0; w4_clr = 1'b0;
    {c2_s, c2_r, c2_clr} = '0;
    #2;
    step();
    step();

    // Reset state
    chk("rst.m0.Q",   32'(m0_q),   32'd0);
    chk("rst.m0.Qn",  32'(m0_qn),  32'd1);
    chk("rst.m0.err", 32'(m0_err), 32'd0);
    chk("rst.m0.stk", 32'(m0_stk), 32'd0);
    chk("rst.m0.cnt", 32'(m0_cnt), 32'd0);
    chk("rst.w4.Qn",  32'(w4_qn),  32'hF);
    rst_n = 1'b1;

    // Basic sequence, mode 0
    m0_vec("t1.set",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    m0_vec("t1.rst",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    m0_vec("t1.set2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    m0_vec("t1.hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    m0_vec("t1.forb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    m0_vec("t1.set3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1.stk", 32'(m0_stk), 32'd1);
    chk("t1.cnt", 32'(m0_cnt), 32'd1);

    // Invalid-state recovery, mode 0
    m0_vec("t2.forb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    m0_vec("t2.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2.cnt", 32'(m0_cnt), 32'd2);

    // Modes 1 and 2, collisions from both Q=0 and Q=1
    m1_s = 1'b1; m1_r = 1'b0; m2_s = 1'b1; m2_r = 1'b1;
    step();
    chk("t3a.m1.Q",   32'(m1_q),   32'd1);
    chk("t3a.m2.Q",   32'(m2_q),   32'd0);
    chk("t3a.m2.Qn",  32'(m2_qn),  32'd1);
    chk("t3a.m2.err", 32'(m2_err), 32'd1);
    m1_s = 1'b1; m1_r = 1'b1; m2_s = 1'b1; m2_r = 1'b0;
    step();
    chk("t3b.m1.Q",   32'(m1_q),   32'd1);
    chk("t3b.m1.Qn",  32'(m1_qn),  32'd0);
    chk("t3b.m1.err", 32'(m1_err), 32'd1);
    chk("t3b.m2.Q",   32'(m2_q),   32'd1);
    m1_s = 1'b0; m1_r = 1'b1; m2_s = 1'b1; m2_r = 1'b1;
    step();
    chk("t3c.m1.Q",   32'(m1_q),   32'd0);
    chk("t3c.m2.Q",   32'(m2_q),   32'd0);
    chk("t3c.m2.Qn",  32'(m2_qn),  32'd1);
    chk("t3c.m2.err", 32'(m2_err), 32'd1);
    m1_s = 1'b1; m1_r = 1'b1; m2_s = 1'b0; m2_r = 1'b0;
    step();
    chk("t3d.m1.Q",   32'(m1_q),   32'd1);
    chk("t3d.m1.Qn",  32'(m1_qn),  32'd0);
    chk("t3d.m1.err", 32'(m1_err), 32'd1);
    chk("t3d.m2.Qn",  32'(m2_qn),  32'd1);
    chk("t3d.m2.err", 32'(m2_err), 32'd0);
    chk("t3d.m1.cnt", 32'(m1_cnt), 32'd2);
    chk("t3d.m2.cnt", 32'(m2_cnt), 32'd2);
    m1_s = 1'b0; m1_r = 1'b0;

    // WIDTH=4 mixed vector
    w4_s = 4'b1010; w4_r = 4'b0110;
    step();
    chk("t4.Q",   32'(w4_q),   32'h8);
    chk("t4.Qn",  32'(w4_qn),  32'h5);
    chk("t4.err", 32'(w4_err), 32'h2);
    chk("t4.cnt", 32'(w4_cnt), 32'd1);
    w4_s = 4'b0000; w4_r = 4'b0000;
    step();
    chk("t4.hold.Qn",  32'(w4_qn),  32'h7);
    chk("t4.hold.err", 32'(w4_err), 32'h0);
    chk("t4.hold.cnt", 32'(w4_cnt), 32'd1);

    // CNT_W=2 saturation, then clr_err against a collision
    c2_s = 1'b1; c2_r = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t5.cnt%0d", k), 32'(c2_cnt), (k > 3) ? 32'd3 : 32'(k));
    end
    chk("t5.stk", 32'(c2_stk), 32'd1);
    c2_clr = 1'b1;
    step();
    chk("t5.clr.cnt", 32'(c2_cnt), 32'd0);
    chk("t5.clr.stk", 32'(c2_stk), 32'd0);
    chk("t5.clr.err", 32'(c2_err), 32'd1);
    c2_clr = 1'b0; c2_s = 1'b0; c2_r = 1'b0;

    // Reset mid-operation with S held high
    m0_vec("t6.set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6.pre.stk", 32'(m0_stk), 32'd1);
    rst_n = 1'b0;
    m0_vec("t6.rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6.rst.stk", 32'(m0_stk), 32'd0);
    chk("t6.rst.cnt", 32'(m0_cnt), 32'd0);
    chk("t6.rst.w4Qn", 32'(w4_qn), 32'hF);
    rst_n = 1'b1;
    m0_vec("t6.rel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
